// File: rtl/ps2_kbd_rx_if.sv
// Key event bus from the PS/2 receiver to the CPC input block.
// Latency: n/a (wiring only).
// Backpressure: none; events are one-cycle strobes with held data fields.
interface ps2_kbd_rx_if;
  logic       key_strobe;
  logic       key_pressed;
  logic       key_extended;
  logic [7:0] key_code;
  logic       frame_err;

  modport master (
    output key_strobe,
    output key_pressed,
    output key_extended,
    output key_code,
    output frame_err
  );

  modport slave (
    input key_strobe,
    input key_pressed,
    input key_extended,
    input key_code,
    input frame_err
  );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: conditions ps2_clk/ps2_data, frames bytes, decodes set-2 prefixes into key events.
// Latency: key_strobe 1 clk after the stop-bit sample; 2 sync + FILTER_LEN clk from a ps2_clk fall to that sample.
// Backpressure: none; events and frame errors are one-cycle pulses that downstream must take.
module ps2_kbd_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 60000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  ps2_kbd_rx_if.master evt
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_t;

  // ---------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          filt_done;
  logic          sample_evt;

  // Two-flop synchronisers; idle PS/2 lines are high, so reset to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // FILTER_LEN-th consecutive differing sample is being seen this cycle.
  assign filt_done  = (clk_s2 != filt_clk) && (filt_cnt == FW'(FILTER_LEN - 1));
  // A high-to-low transition of the filtered clock is the bit sample point.
  assign sample_evt = filt_done && filt_clk;

  // Glitch filter: the filtered level only follows a stable run of new samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_done) begin
      filt_clk <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  // ---------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------
  logic [3:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;
  logic          frame_ok;
  logic          byte_valid;
  logic          byte_bad;

  // Odd parity over data+parity, and the stop bit (sampled now) must be 1.
  assign frame_ok    = (^{shreg, par_bit}) && dat_s2;
  assign byte_valid  = sample_evt && (bitcnt == 4'd10) && frame_ok;
  assign byte_bad    = sample_evt && (bitcnt == 4'd10) && !frame_ok;
  assign timeout_hit = (bitcnt != 4'd0) && (to_cnt == TW'(TIMEOUT));

  // Bit sequencing; a sample event takes priority over a simultaneous timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitcnt  <= 4'd0;
      shreg   <= 8'h00;
      par_bit <= 1'b0;
    end else if (sample_evt) begin
      case (bitcnt)
        4'd0:    if (!dat_s2) bitcnt <= 4'd1;
        4'd9: begin
          par_bit <= dat_s2;
          bitcnt  <= 4'd10;
        end
        4'd10:   bitcnt <= 4'd0;
        default: begin
          shreg  <= {dat_s2, shreg[7:1]};
          bitcnt <= bitcnt + 4'd1;
        end
      endcase
    end else if (timeout_hit) begin
      bitcnt <= 4'd0;
    end
  end

  // Saturating idle counter, cleared at every sample event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (sample_evt) begin
      to_cnt <= '0;
    end else if (to_cnt != TW'(TIMEOUT)) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // ---------------------------------------------------------------
  // Scancode decoder
  // ---------------------------------------------------------------
  state_t     state, state_nxt;
  logic [2:0] skip_cnt, skip_nxt;
  logic       emit;
  logic       emit_pressed;
  logic       emit_ext;
  logic       byte_ignored;

  // Controller responses and error codes carry no key information.
  assign byte_ignored = shreg inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

  // Decoder state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      skip_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  // Prefix tracking and event generation on each received byte.
  always_comb begin
    state_nxt    = state;
    skip_nxt     = skip_cnt;
    emit         = 1'b0;
    emit_pressed = !((state == ST_BRK) || (state == ST_EXT_BRK));
    emit_ext     = (state == ST_EXT) || (state == ST_EXT_BRK);
    if (byte_bad) begin
      state_nxt = ST_IDLE;
    end else if (byte_valid) begin
      if (state == ST_SKIP) begin
        skip_nxt = skip_cnt - 3'd1;
        if (skip_cnt <= 3'd1) state_nxt = ST_IDLE;
      end else begin
        case (shreg)
          8'hE0: state_nxt = (state == ST_EXT_BRK) ? ST_EXT_BRK : ST_EXT;
          8'hF0: begin
            if (state == ST_IDLE)     state_nxt = ST_BRK;
            else if (state == ST_EXT) state_nxt = ST_EXT_BRK;
            else                      state_nxt = ST_IDLE;
          end
          8'hE1: begin
            if (state == ST_IDLE) begin
              state_nxt = ST_SKIP;
              skip_nxt  = 3'd7;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
          default: begin
            if (!((state == ST_IDLE) && byte_ignored)) emit = 1'b1;
            state_nxt = ST_IDLE;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------
  logic       key_strobe_q, key_pressed_q, key_extended_q, frame_err_q;
  logic [7:0] key_code_q;

  // Strobes pulse for one cycle; event fields hold until the next strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_strobe_q   <= 1'b0;
      key_pressed_q  <= 1'b0;
      key_extended_q <= 1'b0;
      key_code_q     <= 8'h00;
      frame_err_q    <= 1'b0;
    end else begin
      key_strobe_q <= emit;
      frame_err_q  <= byte_bad;
      if (emit) begin
        key_pressed_q  <= emit_pressed;
        key_extended_q <= emit_ext;
        key_code_q     <= shreg;
      end
    end
  end

  assign evt.key_strobe   = key_strobe_q;
  assign evt.key_pressed  = key_pressed_q;
  assign evt.key_extended = key_extended_q;
  assign evt.key_code     = key_code_q;
  assign evt.frame_err    = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: serialises PS/2 frames and checks decoded key events.
// Latency: stop-bit ps2_clk fall to visible strobe is 2 + FILTER_LEN clk.
// Backpressure: none; a negedge monitor counts every strobe and frame error.
module tb_ps2_kbd_rx;
  localparam int FILT = 8;
  localparam int TMO  = 500;
  localparam int HALF = 30;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_kbd_rx_if evt_if();

  ps2_kbd_rx #(.FILTER_LEN(FILT), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .evt      (evt_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Event monitor, sampled away from the active edge.
  int         strobe_cnt = 0;
  int         err_cnt = 0;
  int         wide_cnt = 0;
  int         last_strobe_cyc = 0;
  logic       prev_strobe = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] ev_code = 8'h00;
  logic       ev_pressed = 1'b0;
  logic       ev_ext = 1'b0;

  always @(negedge clk) begin
    if (evt_if.key_strobe) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
      ev_code    = evt_if.key_code;
      ev_pressed = evt_if.key_pressed;
      ev_ext     = evt_if.key_extended;
      if (prev_strobe) wide_cnt++;
    end
    if (evt_if.frame_err) begin
      err_cnt++;
      if (prev_err) wide_cnt++;
    end
    prev_strobe = evt_if.key_strobe;
    prev_err    = evt_if.frame_err;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  int drop_cyc = 0;

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clks(HALF);
    ps2_clk  = 1'b0;
    drop_cyc = cyc;
    wait_clks(HALF);
    ps2_clk  = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic flip_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ flip_par);
    send_bit(1'b1);
    ps2_data = 1'b1;
    wait_clks(HALF);
  endtask

  // Start bit plus the first n data bits of b, then the line goes quiet.
  task automatic send_partial(input logic [7:0] b, input int n);
    send_bit(1'b0);
    for (int i = 0; i < n; i++) send_bit(b[i]);
    ps2_data = 1'b1;
  endtask

  int s0, e0;

  initial begin
    // Reset state
    wait_clks(4);
    check("rst_strobe",  evt_if.key_strobe, 0);
    check("rst_pressed", evt_if.key_pressed, 0);
    check("rst_ext",     evt_if.key_extended, 0);
    check("rst_code",    evt_if.key_code, 8'h00);
    check("rst_err",     evt_if.frame_err, 0);
    check("rst_bitcnt",  dut.bitcnt, 0);
    check("rst_filt",    dut.filt_clk, 1);
    reset = 1'b1;
    wait_clks(20);

    // Plain make code with strobe latency
    s0 = strobe_cnt;
    send_byte(8'h1C, 1'b0);
    check("a_cnt",     strobe_cnt - s0, 1);
    check("a_code",    ev_code, 8'h1C);
    check("a_pressed", ev_pressed, 1);
    check("a_ext",     ev_ext, 0);
    check("a_latency", last_strobe_cyc - drop_cyc, 10);

    // Break code
    s0 = strobe_cnt;
    send_byte(8'hF0, 1'b0);
    check("brk_prefix_cnt", strobe_cnt - s0, 0);
    send_byte(8'h1C, 1'b0);
    check("brk_cnt",     strobe_cnt - s0, 1);
    check("brk_code",    ev_code, 8'h1C);
    check("brk_pressed", ev_pressed, 0);
    check("brk_ext",     ev_ext, 0);

    // Extended break then extended-free make
    s0 = strobe_cnt;
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    check("xbrk_cnt",     strobe_cnt - s0, 1);
    check("xbrk_code",    ev_code, 8'h75);
    check("xbrk_pressed", ev_pressed, 0);
    check("xbrk_ext",     ev_ext, 1);
    send_byte(8'h75, 1'b0);
    check("mk75_cnt",     strobe_cnt - s0, 2);
    check("mk75_pressed", ev_pressed, 1);
    check("mk75_ext",     ev_ext, 0);

    // Pause sequence swallowed, following key decoded
    s0 = strobe_cnt;
    send_byte(8'hE1, 1'b0);
    send_byte(8'h14, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'hE1, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h14, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h77, 1'b0);
    check("pause_silent", strobe_cnt - s0, 0);
    send_byte(8'h29, 1'b0);
    check("pause_cnt",     strobe_cnt - s0, 1);
    check("pause_code",    ev_code, 8'h29);
    check("pause_pressed", ev_pressed, 1);

    // Parity error drops the pending break prefix
    s0 = strobe_cnt;
    e0 = err_cnt;
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b1);
    check("perr_err",    err_cnt - e0, 1);
    check("perr_strobe", strobe_cnt - s0, 0);
    send_byte(8'h1C, 1'b0);
    check("perr_next_cnt",     strobe_cnt - s0, 1);
    check("perr_next_pressed", ev_pressed, 1);

    // Responses in IDLE ignored; fake shift emitted as extended
    s0 = strobe_cnt;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hFA, 1'b0);
    check("ign_cnt", strobe_cnt - s0, 0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h12, 1'b0);
    check("fake_cnt",  strobe_cnt - s0, 1);
    check("fake_code", ev_code, 8'h12);
    check("fake_ext",  ev_ext, 1);

    // Timeout abandons a fragment but keeps the decoder's break prefix
    s0 = strobe_cnt;
    e0 = err_cnt;
    send_byte(8'hF0, 1'b0);
    send_partial(8'h29, 4);
    wait_clks(TMO + 200);
    check("tmo_bitcnt", dut.bitcnt, 0);
    check("tmo_strobe", strobe_cnt - s0, 0);
    check("tmo_err",    err_cnt - e0, 0);
    send_byte(8'h29, 1'b0);
    check("tmo_next_cnt",     strobe_cnt - s0, 1);
    check("tmo_next_code",    ev_code, 8'h29);
    check("tmo_next_pressed", ev_pressed, 0);

    // Reset mid-frame after an E0 prefix
    s0 = strobe_cnt;
    send_byte(8'hE0, 1'b0);
    send_partial(8'h5A, 5);
    wait_clks(3);
    reset = 1'b0;
    wait_clks(3);
    check("mrst_strobe",  evt_if.key_strobe, 0);
    check("mrst_pressed", evt_if.key_pressed, 0);
    check("mrst_ext",     evt_if.key_extended, 0);
    check("mrst_code",    evt_if.key_code, 8'h00);
    check("mrst_bitcnt",  dut.bitcnt, 0);
    reset = 1'b1;
    wait_clks(10);
    send_byte(8'h5A, 1'b0);
    check("mrst_next_cnt",     strobe_cnt - s0, 1);
    check("mrst_next_code",    ev_code, 8'h5A);
    check("mrst_next_pressed", ev_pressed, 1);
    check("mrst_next_ext",     ev_ext, 0);

    // Short glitches on ps2_clk while data is low
    s0 = strobe_cnt;
    ps2_data = 1'b0;
    wait_clks(5);
    ps2_clk = 1'b0;
    wait_clks(1);
    ps2_clk = 1'b1;
    wait_clks(20);
    ps2_clk = 1'b0;
    wait_clks(3);
    ps2_clk = 1'b1;
    wait_clks(20);
    check("glitch_bitcnt", dut.bitcnt, 0);
    check("glitch_strobe", strobe_cnt - s0, 0);
    ps2_data = 1'b1;
    wait_clks(10);
    send_byte(8'h4B, 1'b0);
    check("glitch_next_cnt",  strobe_cnt - s0, 1);
    check("glitch_next_code", ev_code, 8'h4B);

    // Pulses must be exactly one cycle wide throughout
    check("pulse_width", wide_cnt, 0);
    check("total_err",   err_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop if the stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- Upstream stage of the CPC input block: receives the PS/2 keyboard serial stream and decodes set-2 scancode sequences into one-cycle key events (strobe, pressed, extended, code).
- Runs in the core clock domain.
- Handles E0 (extended), F0 (break) and E1 (Pause) prefixes.
- Drops bad frames and controller responses.

Parameters:
- FILTER_LEN, 8: consecutive equal synchronised samples required before the filtered ps2_clk level changes.
- TIMEOUT, 60000: clk cycles without a ps2_clk falling edge before a partial frame is abandoned.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset; all state cleared while low.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- key_strobe  out  1  one-cycle pulse per decoded key event.
- key_pressed  out  1  1 = make, 0 = break; valid with strobe, held until next strobe.
- key_extended  out  1  event was E0-prefixed; held as above.
- key_code  out  8  scancode byte; held as above.
- frame_err  out  1  one-cycle pulse on parity/stop error.

Behaviour:
- Reset values: key_strobe 0, key_pressed 0, key_extended 0, key_code 8'h00, frame_err 0; decoder in IDLE; bit counter 0; filtered clk 1.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - Filtered clk takes the new synchronised value only after FILTER_LEN identical consecutive samples.
  - A falling edge of filtered clk is the sample event; ps2_data is sampled at that event.
- Frame receiver (bitcnt 0..10):
  - Bit 0 start: sampled 1 -> ignore, bitcnt stays 0.
  - Bits 1-8: data, LSB first.
  - Bit 9: parity (odd over data+parity).
  - Bit 10: stop, must be 1.
  - On bit 10: if parity ok and stop=1, byte_valid pulses in the same cycle; otherwise frame_err pulses and the decoder returns to IDLE (prefixes discarded). bitcnt -> 0 either way.
- Timeout:
  - Cycle counter is cleared at each sample event and saturates.
  - If bitcnt != 0 and the counter reaches TIMEOUT: bitcnt -> 0, no strobe, no frame_err. Decoder state is unchanged.
- Byte decoder states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP (Pause sequence).
  - Any state except SKIP, byte E0: -> EXT, or stay EXT_BRK if already there.
  - IDLE, byte F0: -> BRK. EXT, byte F0: -> EXT_BRK.
  - IDLE, byte E1: -> SKIP with skip_cnt = 7.
  - SKIP: each byte decrements skip_cnt; at 0 -> IDLE. Nothing is emitted.
  - IDLE, bytes 00, AA, EE, FA, FC, FD, FE, FF: ignored, stay IDLE.
  - Any other byte: emit event, -> IDLE.
    - key_code = byte.
    - key_pressed = 1 unless the state was BRK or EXT_BRK.
    - key_extended = 1 if the state was EXT or EXT_BRK.
    - Event latency: key_strobe high exactly 1 clk after the byte_valid cycle. Data outputs update in the same cycle as the strobe.
  - Bytes E0/F0/E1 arriving in a state not listed above: -> IDLE, no emit.
- Simultaneous events: a timeout and a sample event in the same cycle -> the sample event wins (counter cleared, bit accepted).
- Reset mid-frame or mid-prefix: everything aborts and no strobe is generated; the next start bit after reset release is received normally.
- E0 12 / E0 59 fake-shift codes are emitted as ordinary extended events; downstream ignores them.

Test Plan:
- Frame 1C (A, parity 0, stop 1) -> one strobe, key_pressed=1, key_extended=0, key_code=8'h1C; strobe 1 clk after stop bit accepted.
- Frames F0,1C -> single strobe, key_pressed=0, key_code=1C; no strobe after F0.
- Frames E0,F0,75 -> single strobe, key_pressed=0, key_extended=1, key_code=75; then frame 75 -> key_pressed=1, key_extended=0.
- Pause sequence E1,14,77,E1,F0,14,F0,77 followed by 29 -> exactly one strobe, code 29, pressed=1.
- Frame 1C with parity bit flipped after prefix F0 -> frame_err pulse, no strobe; next 1C -> pressed=1 (prefix discarded).
- 4 data bits then silence > TIMEOUT cycles, then full frame 29 -> no strobe or frame_err from the fragment; one strobe, code 29. Also: reset pulsed low after bit 5 -> outputs at reset values, and the following frame decodes correctly.
- 1-cycle glitch pulses on ps2_clk (shorter than FILTER_LEN) during idle -> no bitcnt change, no strobe.
